// File: rtl/axi_ram_latency_stub_if.sv
// AXI4 read-address and read-data channel bundle for the latency-stub RAM.
// The slave modport is the RAM side; the master modport is the requester side.
interface axi_ram_latency_stub_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 8,
    parameter int ID_WIDTH   = 8,
    parameter int LEN_WIDTH  = 8
);
    logic                  s_axi_arvalid;
    logic                  s_axi_arready;
    logic [ADDR_WIDTH-1:0] s_axi_araddr;
    logic [LEN_WIDTH-1:0]  s_axi_arlen;
    logic [ID_WIDTH-1:0]   s_axi_arid;

    logic                  s_axi_rvalid;
    logic                  s_axi_rready;
    logic [DATA_WIDTH-1:0] s_axi_rdata;
    logic [ID_WIDTH-1:0]   s_axi_rid;
    logic                  s_axi_rlast;
    logic [1:0]            s_axi_rresp;

    modport slave (
        input  s_axi_arvalid, s_axi_araddr, s_axi_arlen, s_axi_arid, s_axi_rready,
        output s_axi_arready, s_axi_rvalid, s_axi_rdata, s_axi_rid, s_axi_rlast, s_axi_rresp
    );

    modport master (
        output s_axi_arvalid, s_axi_araddr, s_axi_arlen, s_axi_arid, s_axi_rready,
        input  s_axi_arready, s_axi_rvalid, s_axi_rdata, s_axi_rid, s_axi_rlast, s_axi_rresp
    );
endinterface

// File: rtl/axi_ram_latency_stub.sv
// AXI read-only RAM model with a fixed first-beat latency, an in-order request
// queue, optional periodic rvalid bubbles and a handshake-free preload port.
module axi_ram_latency_stub #(
    parameter int DATA_WIDTH      = 8,
    parameter int ADDR_WIDTH      = 32,
    parameter int ID_WIDTH        = 8,
    parameter int LEN_WIDTH       = 8,
    parameter int MEM_WORDS_LOG   = 16,
    parameter int LOG_OUTSTANDING = 2,
    parameter int READ_LATENCY    = 4,
    parameter int STALL_PERIOD    = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    axi_ram_latency_stub_if.slave    s_axi,
    input  logic                     wr_en,
    input  logic [ADDR_WIDTH-1:0]    wr_addr,
    input  logic [DATA_WIDTH-1:0]    wr_data,
    output logic [LOG_OUTSTANDING:0] outstanding
);

    localparam int BYTE_SHIFT = $clog2(DATA_WIDTH / 8);
    localparam int MEM_DEPTH  = 1 << MEM_WORDS_LOG;
    localparam int QDEPTH     = 1 << LOG_OUTSTANDING;
    localparam int CD_W       = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam int SC_W       = (STALL_PERIOD > 0) ? $clog2(STALL_PERIOD + 1) : 1;

    typedef logic [MEM_WORDS_LOG-1:0]   widx_t;
    typedef logic [LOG_OUTSTANDING-1:0] ptr_t;
    typedef logic [LOG_OUTSTANDING:0]   count_t;
    typedef logic [CD_W-1:0]            cd_t;
    typedef logic [SC_W-1:0]            sc_t;

    typedef struct packed {
        widx_t                base;
        logic [LEN_WIDTH-1:0] len;
        logic [ID_WIDTH-1:0]  id;
    } req_t;

    localparam cd_t CD_INIT  = cd_t'(READ_LATENCY - 1);
    localparam sc_t SC_LIMIT = sc_t'(STALL_PERIOD - 1);

    // Byte address to word index; offset bits dropped, upper bits wrap away.
    function automatic widx_t word_index(input logic [ADDR_WIDTH-1:0] addr);
        return widx_t'(addr >> BYTE_SHIFT);
    endfunction

    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
    req_t                  fifo_q [QDEPTH];
    cd_t                   cd_q   [QDEPTH];

    ptr_t                  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    count_t                count_q, count_d;
    logic [LEN_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;
    sc_t                   stall_cnt_q, stall_cnt_d;
    logic                  rvalid_q, rvalid_d, rlast_q, rlast_d;
    logic [ID_WIDTH-1:0]   rid_q, rid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic                  arready, push, hs, pop, bubble, load;
    logic                  cand_avail;
    ptr_t                  cand_ptr;
    logic [LEN_WIDTH-1:0]  cand_beat;
    req_t                  cand;

    assign arready     = count_q < count_t'(QDEPTH);
    assign push        = s_axi.s_axi_arvalid && arready;
    assign outstanding = count_q;

    assign s_axi.s_axi_arready = arready;
    assign s_axi.s_axi_rvalid  = rvalid_q;
    assign s_axi.s_axi_rdata   = rdata_q;
    assign s_axi.s_axi_rid     = rid_q;
    assign s_axi.s_axi_rlast   = rlast_q;
    assign s_axi.s_axi_rresp   = 2'b00;

    // Preload write port into the backing store.
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset; contents must survive rst and a reset loop would not map to RAM.
        if (wr_en) begin
            mem_q[word_index(wr_addr)] <= wr_data;
        end
    end

    // Request-queue payload and per-entry latency countdowns (pointers qualify validity).
    always_ff @(posedge clk) begin
        for (int i = 0; i < QDEPTH; i++) begin
            if (cd_q[i] != '0) begin
                cd_q[i] <= cd_q[i] - 1'b1;
            end
        end
        if (push) begin
            fifo_q[wr_ptr_q] <= '{base: word_index(s_axi.s_axi_araddr),
                                  len:  s_axi.s_axi_arlen,
                                  id:   s_axi.s_axi_arid};
            cd_q[wr_ptr_q]   <= CD_INIT;
        end
    end

    // Next-state logic: pick the burst allowed to emit, decide load/bubble, update counters.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no path leaves one unassigned (no latches).
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        beat_cnt_d  = beat_cnt_q;
        stall_cnt_d = stall_cnt_q;
        rvalid_d    = rvalid_q;
        rlast_d     = rlast_q;
        rid_d       = rid_q;
        rdata_d     = rdata_q;

        hs  = rvalid_q && s_axi.s_axi_rready;
        pop = hs && rlast_q;

        // Once the head's last beat is on the bus, the following burst is the load candidate.
        if (rvalid_q && rlast_q) begin
            cand_ptr   = rd_ptr_q + 1'b1;
            cand_avail = count_q > count_t'(1);
            cand_beat  = '0;
        end else begin
            cand_ptr   = rd_ptr_q;
            cand_avail = count_q != '0;
            cand_beat  = beat_cnt_q;
        end
        cand = fifo_q[cand_ptr];

        bubble = (STALL_PERIOD > 0) && hs && (stall_cnt_q == SC_LIMIT);
        load   = cand_avail && (cd_q[cand_ptr] == '0) && !bubble &&
                 (!rvalid_q || s_axi.s_axi_rready);

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if ((STALL_PERIOD > 0) && hs) begin
            stall_cnt_d = bubble ? '0 : stall_cnt_q + 1'b1;
        end

        if (load) begin
            rvalid_d   = 1'b1;
            rdata_d    = mem_q[cand.base + widx_t'(cand_beat)];
            rid_d      = cand.id;
            rlast_d    = (cand_beat == cand.len);
            beat_cnt_d = (cand_beat == cand.len) ? '0 : cand_beat + 1'b1;
        end else if (hs) begin
            rvalid_d = 1'b0;
        end
    end

    // Control and R-channel output registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            beat_cnt_q  <= '0;
            stall_cnt_q <= '0;
            rvalid_q    <= 1'b0;
            rlast_q     <= 1'b0;
            rid_q       <= '0;
            rdata_q     <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            beat_cnt_q  <= beat_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            rvalid_q    <= rvalid_d;
            rlast_q     <= rlast_d;
            rid_q       <= rid_d;
            rdata_q     <= rdata_d;
        end
    end

endmodule

// File: tb/tb_axi_ram_latency_stub.sv
// Self-checking bench: instance A uses default parameters, instance B uses a
// 16-word memory with STALL_PERIOD=2. Expected beats go to per-instance
// scoreboard queues when requests are issued and are compared as they are accepted.
module tb_axi_ram_latency_stub;

    localparam int AW = 32;
    localparam int DW = 8;
    localparam int IW = 8;
    localparam int LW = 8;

    typedef struct {
        logic [DW-1:0] data;
        logic [IW-1:0] id;
        logic          last;
    } beat_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [LW-1:0] len;
        logic [IW-1:0] id;
        logic [DW-1:0] data0;  // beat n must return data0 + n
        bit            bp;     // randomise rready while draining
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    beat_t sb_a[$];
    beat_t sb_b[$];

    axi_ram_latency_stub_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .LEN_WIDTH(LW)) if_a ();
    axi_ram_latency_stub_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .LEN_WIDTH(LW)) if_b ();

    logic          a_wr_en, b_wr_en;
    logic [AW-1:0] a_wr_addr, b_wr_addr;
    logic [DW-1:0] a_wr_data, b_wr_data;
    logic [2:0]    a_out, b_out;

    axi_ram_latency_stub #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .LEN_WIDTH(LW),
        .MEM_WORDS_LOG(16), .LOG_OUTSTANDING(2), .READ_LATENCY(4), .STALL_PERIOD(0)
    ) u_dut_a (
        .clk(clk), .rst(rst), .s_axi(if_a),
        .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data), .outstanding(a_out)
    );

    axi_ram_latency_stub #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .LEN_WIDTH(LW),
        .MEM_WORDS_LOG(4), .LOG_OUTSTANDING(2), .READ_LATENCY(4), .STALL_PERIOD(2)
    ) u_dut_b (
        .clk(clk), .rst(rst), .s_axi(if_b),
        .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data), .outstanding(b_out)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic rv(input bit sel);
        return sel ? if_b.s_axi_rvalid : if_a.s_axi_rvalid;
    endfunction

    function automatic logic rrdy(input bit sel);
        return sel ? if_b.s_axi_rready : if_a.s_axi_rready;
    endfunction

    function automatic logic arr(input bit sel);
        return sel ? if_b.s_axi_arready : if_a.s_axi_arready;
    endfunction

    function automatic int sb_size(input bit sel);
        return sel ? sb_b.size() : sb_a.size();
    endfunction

    task automatic set_rready(input bit sel, input logic v);
        if (sel) if_b.s_axi_rready = v;
        else     if_a.s_axi_rready = v;
    endtask

    task automatic exp_beat(input bit sel, input logic [DW-1:0] d, input logic [IW-1:0] id, input logic last);
        beat_t b;
        b = '{data: d, id: id, last: last};
        if (sel) sb_b.push_back(b);
        else     sb_a.push_back(b);
    endtask

    task automatic exp_seq(input bit sel, input logic [IW-1:0] id, input logic [LW-1:0] len, input logic [DW-1:0] d0);
        for (int n = 0; n <= int'(len); n++) begin
            exp_beat(sel, DW'(int'(d0) + n), id, n == int'(len));
        end
    endtask

    // Called at posedge+#1; returns at posedge+#1 after the write edge.
    task automatic preload(input bit sel, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        if (sel) begin b_wr_en = 1'b1; b_wr_addr = addr; b_wr_data = data; end
        else     begin a_wr_en = 1'b1; a_wr_addr = addr; a_wr_data = data; end
        @(posedge clk); #1;
        a_wr_en = 1'b0;
        b_wr_en = 1'b0;
    endtask

    // Holds arvalid until accepted; hs_edge is the cycle number of the accepting edge.
    task automatic issue_ar(input bit sel, input logic [AW-1:0] addr, input logic [LW-1:0] len,
                            input logic [IW-1:0] id, output int hs_edge);
        if (sel) begin
            if_b.s_axi_arvalid = 1'b1; if_b.s_axi_araddr = addr; if_b.s_axi_arlen = len; if_b.s_axi_arid = id;
        end else begin
            if_a.s_axi_arvalid = 1'b1; if_a.s_axi_araddr = addr; if_a.s_axi_arlen = len; if_a.s_axi_arid = id;
        end
        hs_edge = -1;
        for (int t = 0; t < 200 && hs_edge < 0; t++) begin
            @(negedge clk);
            if (arr(sel)) hs_edge = cyc + 1;
            @(posedge clk); #1;
        end
        if (sel) if_b.s_axi_arvalid = 1'b0;
        else     if_a.s_axi_arvalid = 1'b0;
        if (hs_edge < 0) check(sel ? "b_ar_accept_timeout" : "a_ar_accept_timeout", 64'(arr(sel)), 64'd1);
    endtask

    // Returns at the negedge where rvalid is first seen high.
    task automatic wait_rvalid(input bit sel, input int max_cyc);
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!rv(sel) && t < max_cyc);
        check(sel ? "b_rvalid_seen" : "a_rvalid_seen", 64'(rv(sel)), 64'd1);
    endtask

    // Runs until the scoreboard empties (bounded); returns at posedge+#1 with rready=1.
    task automatic drain(input bit sel, input bit bp, input int max_cyc);
        for (int t = 0; t < max_cyc; t++) begin
            if (sb_size(sel) == 0) break;
            @(posedge clk); #1;
            set_rready(sel, bp ? 1'($urandom_range(0, 1)) : 1'b1);
        end
        set_rready(sel, 1'b1);
        check(sel ? "b_drain_empty" : "a_drain_empty", 64'(sb_size(sel)), 64'd0);
    endtask

    // Scoreboard and hold-stability monitor for instance A.
    logic  a_prev_stall = 1'b0;
    beat_t a_prev;
    always @(negedge clk) begin
        if (rst) begin
            a_prev_stall = 1'b0;
        end else begin
            if (a_prev_stall) begin
                check("a_hold_stable", {if_a.s_axi_rvalid, if_a.s_axi_rdata, if_a.s_axi_rid, if_a.s_axi_rlast},
                      {1'b1, a_prev.data, a_prev.id, a_prev.last});
            end
            if (if_a.s_axi_rvalid && if_a.s_axi_rready) begin
                if (sb_a.size() == 0) begin
                    check("a_unexpected_beat", 64'(if_a.s_axi_rvalid), 64'd0);
                end else begin
                    beat_t e;
                    e = sb_a.pop_front();
                    check("a_beat", {if_a.s_axi_rdata, if_a.s_axi_rid, if_a.s_axi_rlast, if_a.s_axi_rresp},
                          {e.data, e.id, e.last, 2'b00});
                end
            end
            a_prev_stall = if_a.s_axi_rvalid && !if_a.s_axi_rready;
            a_prev       = '{data: if_a.s_axi_rdata, id: if_a.s_axi_rid, last: if_a.s_axi_rlast};
        end
    end

    // Scoreboard and hold-stability monitor for instance B.
    logic  b_prev_stall = 1'b0;
    beat_t b_prev;
    always @(negedge clk) begin
        if (rst) begin
            b_prev_stall = 1'b0;
        end else begin
            if (b_prev_stall) begin
                check("b_hold_stable", {if_b.s_axi_rvalid, if_b.s_axi_rdata, if_b.s_axi_rid, if_b.s_axi_rlast},
                      {1'b1, b_prev.data, b_prev.id, b_prev.last});
            end
            if (if_b.s_axi_rvalid && if_b.s_axi_rready) begin
                if (sb_b.size() == 0) begin
                    check("b_unexpected_beat", 64'(if_b.s_axi_rvalid), 64'd0);
                end else begin
                    beat_t e;
                    e = sb_b.pop_front();
                    check("b_beat", {if_b.s_axi_rdata, if_b.s_axi_rid, if_b.s_axi_rlast, if_b.s_axi_rresp},
                          {e.data, e.id, e.last, 2'b00});
                end
            end
            b_prev_stall = if_b.s_axi_rvalid && !if_b.s_axi_rready;
            b_prev       = '{data: if_b.s_axi_rdata, id: if_b.s_axi_rid, last: if_b.s_axi_rlast};
        end
    end

    // Watchdog: a hang is reported and the run ends.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    vec_t vecs[5];
    int   hs, hs5, pop_edge, n_after;
    logic [7:0] pat;

    initial begin
        vecs[0] = '{addr: 32'h0000_0100, len: 8'd0,  id: 8'h01, data0: 8'h11, bp: 1'b0};
        vecs[1] = '{addr: 32'h0000_0200, len: 8'd3,  id: 8'h02, data0: 8'h21, bp: 1'b1};
        vecs[2] = '{addr: 32'h0000_FFFF, len: 8'd2,  id: 8'h03, data0: 8'hE0, bp: 1'b0};
        vecs[3] = '{addr: 32'h1234_5678, len: 8'd4,  id: 8'h04, data0: 8'h44, bp: 1'b1};
        vecs[4] = '{addr: 32'h0000_0300, len: 8'd15, id: 8'h09, data0: 8'hF8, bp: 1'b1};

        rst = 1'b1;
        a_wr_en = 1'b0; a_wr_addr = '0; a_wr_data = '0;
        b_wr_en = 1'b0; b_wr_addr = '0; b_wr_data = '0;
        if_a.s_axi_arvalid = 1'b0; if_a.s_axi_araddr = '0; if_a.s_axi_arlen = '0; if_a.s_axi_arid = '0;
        if_b.s_axi_arvalid = 1'b0; if_b.s_axi_araddr = '0; if_b.s_axi_arlen = '0; if_b.s_axi_arid = '0;
        if_a.s_axi_rready = 1'b1;
        if_b.s_axi_rready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state.
        @(negedge clk);
        check("a_reset_arready", 64'(if_a.s_axi_arready), 64'd1);
        check("a_reset_rvalid", 64'(if_a.s_axi_rvalid), 64'd0);
        check("a_reset_outstanding", 64'(a_out), 64'd0);
        check("a_reset_rdata_rid_rlast", {if_a.s_axi_rdata, if_a.s_axi_rid, if_a.s_axi_rlast}, 64'd0);
        check("b_reset_rvalid_outstanding", {if_b.s_axi_rvalid, b_out}, 64'd0);
        @(posedge clk); #1;

        // Single beat latency: AR accepted at edge k, rvalid after edge k+4.
        preload(0, 32'h0000_BEEF, 8'hFF);
        exp_seq(0, 8'h05, 8'd0, 8'hFF);
        issue_ar(0, 32'h0000_BEEF, 8'd0, 8'h05, hs);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("a_latency_idle", 64'(if_a.s_axi_rvalid), 64'd0);
        end
        @(negedge clk);
        check("a_latency_first", {if_a.s_axi_rvalid, if_a.s_axi_rdata, if_a.s_axi_rid, if_a.s_axi_rlast},
              {1'b1, 8'hFF, 8'h05, 1'b1});
        @(posedge clk); #1;
        drain(0, 1'b0, 20);

        // Table-driven bursts: preload, issue, drain.
        foreach (vecs[v]) begin
            for (int n = 0; n <= int'(vecs[v].len); n++) begin
                preload(0, AW'((int'(vecs[v].addr[15:0]) + n) % 65536), DW'(int'(vecs[v].data0) + n));
            end
            exp_seq(0, vecs[v].id, vecs[v].len, vecs[v].data0);
            issue_ar(0, vecs[v].addr, vecs[v].len, vecs[v].id, hs);
            drain(0, vecs[v].bp, 300);
        end

        // rready held low for 3 cycles on the first beat of a 4-beat burst.
        for (int i = 0; i < 4; i++) preload(0, AW'(32'h10 + i), DW'(8'hA0 + i));
        if_a.s_axi_rready = 1'b0;
        exp_seq(0, 8'h01, 8'd3, 8'hA0);
        issue_ar(0, 32'h10, 8'd3, 8'h01, hs);
        wait_rvalid(0, 20);
        repeat (2) begin
            @(negedge clk);
            check("a_stalled_beat0", {if_a.s_axi_rvalid, if_a.s_axi_rdata, if_a.s_axi_rlast}, {1'b1, 8'hA0, 1'b0});
        end
        @(posedge clk); #1;
        if_a.s_axi_rready = 1'b1;
        drain(0, 1'b0, 20);

        // Queue full: four bursts fill it, the fifth waits for the first pop.
        for (int i = 0; i < 10; i++) preload(0, AW'(32'h20 + i), DW'(8'h30 + i));
        if_a.s_axi_rready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_seq(0, IW'(8'h11 + i), 8'd1, DW'(8'h30 + 2 * i));
            issue_ar(0, AW'(32'h20 + 2 * i), 8'd1, IW'(8'h11 + i), hs);
        end
        @(negedge clk);
        check("a_full_arready", 64'(if_a.s_axi_arready), 64'd0);
        check("a_full_outstanding", 64'(a_out), 64'd4);
        @(posedge clk); #1;
        pop_edge = -1;
        fork
            begin
                exp_seq(0, 8'h15, 8'd1, 8'h38);
                issue_ar(0, 32'h28, 8'd1, 8'h15, hs5);
            end
            begin
                @(negedge clk);
                check("a_full_arready_held", 64'(if_a.s_axi_arready), 64'd0);
                @(posedge clk); #1;
                if_a.s_axi_rready = 1'b1;
                for (int t = 0; t < 50; t++) begin
                    @(negedge clk);
                    if (if_a.s_axi_rvalid && if_a.s_axi_rready && if_a.s_axi_rlast) begin
                        pop_edge = cyc + 1;
                        break;
                    end
                end
            end
        join
        check("a_ar5_after_pop", 64'(hs5), 64'(pop_edge + 1));
        drain(0, 1'b0, 100);
        @(negedge clk);
        check("a_outstanding_drained", 64'(a_out), 64'd0);
        @(posedge clk); #1;

        // Reset during beat 2 of an 8-beat burst.
        for (int i = 0; i < 8; i++) preload(0, AW'(32'h40 + i), DW'(8'h70 + i));
        exp_seq(0, 8'h37, 8'd7, 8'h70);
        issue_ar(0, 32'h40, 8'd7, 8'h37, hs);
        wait_rvalid(0, 20);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb_a.delete();
        @(negedge clk);
        check("a_rst_mid_rvalid", 64'(if_a.s_axi_rvalid), 64'd0);
        check("a_rst_mid_outstanding", 64'(a_out), 64'd0);
        check("a_rst_mid_arready", 64'(if_a.s_axi_arready), 64'd1);
        n_after = 0;
        repeat (20) begin
            @(negedge clk);
            if (if_a.s_axi_rvalid) n_after++;
        end
        check("a_no_beats_after_rst", 64'(n_after), 64'd0);
        @(posedge clk); #1;
        exp_seq(0, 8'h38, 8'd0, 8'h73);
        issue_ar(0, 32'h43, 8'd0, 8'h38, hs);
        drain(0, 1'b0, 20);

        // Instance B: periodic bubbles, then wrap in a 16-word memory.
        for (int i = 0; i < 16; i++) preload(1, AW'(i), DW'(8'h50 + i));
        exp_seq(1, 8'h21, 8'd5, 8'h52);
        issue_ar(1, 32'h2, 8'd5, 8'h21, hs);
        wait_rvalid(1, 20);
        pat = 8'h01;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            pat = {pat[6:0], if_b.s_axi_rvalid};
        end
        check("b_stall_pattern", 64'(pat), 64'(8'b1101_1011));
        @(posedge clk); #1;
        drain(1, 1'b0, 20);

        exp_beat(1, 8'h5E, 8'h22, 1'b0);
        exp_beat(1, 8'h5F, 8'h22, 1'b0);
        exp_beat(1, 8'h50, 8'h22, 1'b0);
        exp_beat(1, 8'h51, 8'h22, 1'b1);
        issue_ar(1, 32'hE, 8'd3, 8'h22, hs);
        drain(1, 1'b1, 100);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
